// File: rtl/count_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_ctrl_pkg
//  Description : Shared definitions for the count sequence controller:
//                state encoding, default counter width and the helper
//                that turns a 4-bit pass request into a pass target.
//  Revision    : 1.0 - initial release
// ============================================================================
package count_seq_ctrl_pkg;

    localparam int c_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A pass request of 0 means a full 16 passes, so the target needs 5 bits.
    function automatic logic [4:0] f_pass_target(input logic [3:0] passes);
        return (passes == 4'd0) ? 5'd16 : {1'b0, passes};
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_ctrl_if
//  Description : Control/status bundle of the count sequence controller.
//                master : drives config and commands, observes status.
//                slave  : the controller side.
//  Ports       : start, up_first, bounce, lo, hi, passes, hold, abort
//                (master -> slave); count, dir, pass_idx, busy, done, err
//                (slave -> master).
//  Revision    : 1.0 - initial release
// ============================================================================
interface count_seq_ctrl_if
    import count_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
);
    logic             start;
    logic             up_first;
    logic             bounce;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [3:0]       passes;
    logic             hold;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic [3:0]       pass_idx;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, up_first, bounce, lo, hi, passes, hold, abort,
        input  count, dir, pass_idx, busy, done, err
    );

    modport slave (
        input  start, up_first, bounce, lo, hi, passes, hold, abort,
        output count, dir, pass_idx, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/count_seq_ctrl_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bounded_updown_counter
//  Description : Loadable up/down counter. Load has priority over enable.
//                It never decides on bounds itself; the controller only
//                enables a step when the count is strictly inside the bound
//                being approached, so the count cannot wrap.
//  Ports       : clk, reset (async, active-high), load, load_val, en, up,
//                count (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module bounded_updown_counter
    import count_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             en,
    input  wire logic             up,
    output logic      [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= up ? (r_count + 1'b1) : (r_count - 1'b1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/count_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_ctrl
//  Description : Sweeps a counter between latched bounds lo..hi for a
//                programmable number of passes, either reloading the start
//                bound or bouncing at each pass end. Supports hold, abort
//                and rejects starts with lo > hi via a one-cycle err pulse.
//  Ports       : clk, reset (async, active-high), bus (count_seq_ctrl_if
//                slave: start/up_first/bounce/lo/hi/passes/hold/abort in,
//                count/dir/pass_idx/busy/done/err out)
//  Revision    : 1.0 - initial release
// ============================================================================
module count_seq_ctrl
    import count_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        reset,
    count_seq_ctrl_if.slave  bus
);

    // Latched run configuration
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_up_first;
    logic             r_bounce;
    logic [4:0]       r_target;

    // Control state
    state_t           r_state;
    logic             r_dir;
    logic [4:0]       r_pass;
    logic             r_err;

    // Next-state / datapath controls
    state_t           w_state_nxt;
    logic             w_dir_nxt;
    logic [4:0]       w_pass_nxt;
    logic             w_err_nxt;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;
    logic             w_en;
    logic             w_up;
    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_end_bound;
    logic [4:0]       w_pass_inc;

    assign w_end_bound = r_dir ? r_hi : r_lo;
    assign w_pass_inc  = r_pass + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_dir   <= 1'b1;
            r_pass  <= 5'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo       <= '0;
            r_hi       <= '0;
            r_up_first <= 1'b1;
            r_bounce   <= 1'b0;
            r_target   <= 5'd16;
        end else if (w_accept) begin
            r_lo       <= bus.lo;
            r_hi       <= bus.hi;
            r_up_first <= bus.up_first;
            r_bounce   <= bus.bounce;
            r_target   <= f_pass_target(bus.passes);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_pass_nxt  = r_pass;
        w_err_nxt   = 1'b0;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_load_val  = r_lo;
        w_en        = 1'b0;
        w_up        = r_dir;

        if (bus.abort) begin
            // Abort wins over everything; count simply stays where it is.
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.lo <= bus.hi) begin
                            w_accept    = 1'b1;
                            w_state_nxt = RUN;
                            w_load      = 1'b1;
                            w_load_val  = bus.up_first ? bus.lo : bus.hi;
                            w_dir_nxt   = bus.up_first;
                            w_pass_nxt  = 5'd0;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!bus.hold) begin
                        if (w_count != w_end_bound) begin
                            w_en = 1'b1;
                        end else begin
                            w_pass_nxt = w_pass_inc;
                            if (w_pass_inc == r_target) begin
                                w_state_nxt = DONE;
                            end else if (r_bounce) begin
                                // Turn around and take the first step of the
                                // new pass now so the bound is not repeated.
                                // With lo == hi there is nowhere to step.
                                w_dir_nxt = ~r_dir;
                                w_up      = ~r_dir;
                                w_en      = (r_lo != r_hi);
                            end else begin
                                w_load     = 1'b1;
                                w_load_val = r_up_first ? r_lo : r_hi;
                            end
                        end
                    end
                end
                DONE: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    bounded_updown_counter #(
        .WIDTH    (WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_en),
        .up       (w_up),
        .count    (w_count)
    );

    assign bus.count    = w_count;
    assign bus.dir      = r_dir;
    // After 16 passes the 4-bit index reads 0; the 5-bit counter keeps the
    // full value for the completion compare.
    assign bus.pass_idx = r_pass[3:0];
    assign bus.busy     = (r_state == RUN);
    assign bus.done     = (r_state == DONE);
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_seq_ctrl
//  Description : Self-checking bench for count_seq_ctrl: directed table,
//                hand-written corner sequences and randomized runs checked
//                against a sequence model built from the sweep rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_seq_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    count_seq_ctrl_if #(.WIDTH(W)) bus ();

    count_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int lo;
        int hi;
        int up_first;
        int bounce;
        int passes;
        int is_err;
        int cycles;
        int fcount;
        int fpidx;
        int fdir;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int lo, input int hi, input int up, input int b, input int p);
        bus.lo       = W'(lo);
        bus.hi       = W'(hi);
        bus.up_first = up[0];
        bus.bounce   = b[0];
        bus.passes   = 4'(p);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        // Scramble the config inputs; the run must use the latched copy.
        bus.lo       = W'($urandom);
        bus.hi       = W'($urandom);
        bus.up_first = 1'($urandom);
        bus.bounce   = 1'($urandom);
        bus.passes   = 4'($urandom);
    endtask

    // Expected count for every RUN cycle, derived from the sweep rules.
    int q[$];
    int model_fdir;

    task automatic build_model(input int lo, input int hi, input int up, input int b, input int p);
        int n, d, s, e, v;
        q.delete();
        n = (p == 0) ? 16 : p;
        d = up;
        for (int k = 0; k < n; k++) begin
            s = d ? lo : hi;
            e = d ? hi : lo;
            if (b != 0 && k > 0 && lo != hi) s = d ? lo + 1 : hi - 1;
            v = s;
            q.push_back(v);
            while (v != e) begin
                v = d ? v + 1 : v - 1;
                q.push_back(v);
            end
            model_fdir = d;
            if (b != 0) d = 1 - d;
        end
    endtask

    task automatic expect_run(input string name, input int v);
        check({name, "_busy"}, 32'(bus.busy), 32'd1);
        check({name, "_count"}, 32'(bus.count), 32'(v));
    endtask

    vec_t tbl[$];

    initial begin
        int n;
        int idx;
        int cyc;
        int lo, hi, up, b, p;
        logic h;

        bus.start = 0; bus.up_first = 0; bus.bounce = 0; bus.lo = 0; bus.hi = 0;
        bus.passes = 0; bus.hold = 0; bus.abort = 0;
        reset = 1'b1;
        #23;
        check("rst_count", 32'(bus.count), 0);
        check("rst_dir", 32'(bus.dir), 1);
        check("rst_pidx", 32'(bus.pass_idx), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        reset = 1'b0;
        tick();

        // ---------------- directed table ----------------
        //          lo  hi up  b  p err cyc fcnt fpidx fdir
        tbl.push_back('{3,  6, 1, 0, 2, 0,  8,  6, 2, 1});
        tbl.push_back('{3,  5, 1, 1, 2, 0,  5,  3, 2, 0});
        tbl.push_back('{0, 15, 0, 0, 1, 0, 16,  0, 1, 0});
        tbl.push_back('{9,  2, 1, 0, 1, 1,  0,  0, 1, 0});
        tbl.push_back('{7,  7, 1, 0, 0, 0, 16,  7, 0, 1});
        tbl.push_back('{0, 15, 1, 1, 3, 0, 46, 15, 3, 1});
        tbl.push_back('{15,15, 0, 1, 3, 0,  3, 15, 3, 0});
        tbl.push_back('{2,  4, 0, 0, 3, 0,  9,  2, 3, 0});
        tbl.push_back('{0,  0, 1, 1, 2, 0,  2,  0, 2, 0});

        foreach (tbl[i]) begin
            start_run(tbl[i].lo, tbl[i].hi, tbl[i].up_first, tbl[i].bounce, tbl[i].passes);
            if (tbl[i].is_err != 0) begin
                check("tbl_err_pulse", 32'(bus.err), 1);
                check("tbl_err_busy", 32'(bus.busy), 0);
                check("tbl_err_count", 32'(bus.count), 32'(tbl[i].fcount));
                check("tbl_err_pidx", 32'(bus.pass_idx), 32'(tbl[i].fpidx));
                check("tbl_err_dir", 32'(bus.dir), 32'(tbl[i].fdir));
                tick();
                check("tbl_err_once", 32'(bus.err), 0);
                check("tbl_err_busy2", 32'(bus.busy), 0);
            end else begin
                n = bus.busy ? 1 : 0;
                while (bus.busy && n < 400) begin
                    tick();
                    if (bus.busy) n++;
                end
                check("tbl_cycles", 32'(n), 32'(tbl[i].cycles));
                check("tbl_done", 32'(bus.done), 1);
                check("tbl_fcount", 32'(bus.count), 32'(tbl[i].fcount));
                check("tbl_fpidx", 32'(bus.pass_idx), 32'(tbl[i].fpidx));
                check("tbl_fdir", 32'(bus.dir), 32'(tbl[i].fdir));
                tick();
                check("tbl_done_once", 32'(bus.done), 0);
                check("tbl_idle_count", 32'(bus.count), 32'(tbl[i].fcount));
            end
        end

        // ---------------- hold for 3 cycles at 5 ----------------
        start_run(3, 6, 1, 0, 2);
        expect_run("hs_a", 3); tick();
        expect_run("hs_b", 4); tick();
        expect_run("hs_c", 5);
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_run("hs_hold", 5);
        end
        bus.hold = 1'b0;
        tick(); expect_run("hs_d", 6);
        tick(); expect_run("hs_e", 3);
        tick(); expect_run("hs_f", 4);
        tick(); expect_run("hs_g", 5);
        tick(); expect_run("hs_h", 6);
        check("hs_pidx", 32'(bus.pass_idx), 1);
        tick();
        check("hs_done", 32'(bus.done), 1);
        check("hs_fcount", 32'(bus.count), 6);
        check("hs_fpidx", 32'(bus.pass_idx), 2);
        // hold is meaningless in DONE: still returns to IDLE
        bus.hold = 1'b1;
        tick();
        bus.hold = 1'b0;
        check("hs_idle_busy", 32'(bus.busy), 0);
        check("hs_idle_done", 32'(bus.done), 0);

        // ---------------- ignored start in RUN, then abort at 4 ----------------
        start_run(3, 6, 1, 0, 2);
        expect_run("ab_a", 3);
        bus.lo = 4'd9; bus.hi = 4'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_run("ab_b", 4);
        check("ab_no_err", 32'(bus.err), 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("ab_busy", 32'(bus.busy), 0);
        check("ab_count", 32'(bus.count), 4);
        check("ab_done", 32'(bus.done), 0);
        tick();
        check("ab_done2", 32'(bus.done), 0);
        check("ab_count2", 32'(bus.count), 4);

        // ---------------- hold ignored in IDLE ----------------
        bus.hold = 1'b1;
        start_run(1, 2, 1, 0, 1);
        bus.hold = 1'b0;
        expect_run("hi_a", 1); tick();
        expect_run("hi_b", 2); tick();
        check("hi_done", 32'(bus.done), 1);

        // ---------------- asynchronous reset mid-run ----------------
        tick();
        start_run(3, 6, 1, 0, 2);
        tick();
        expect_run("rs_pre", 4);
        #3 reset = 1'b1;
        #1;
        check("rs_count", 32'(bus.count), 0);
        check("rs_busy", 32'(bus.busy), 0);
        check("rs_dir", 32'(bus.dir), 1);
        #2 reset = 1'b0;
        tick();
        check("rs_idle", 32'(bus.busy), 0);
        check("rs_nodone", 32'(bus.done), 0);
        start_run(10, 11, 0, 0, 1);
        expect_run("rs_resume", 11);
        tick(); tick();
        check("rs_resume_done", 32'(bus.done), 1);
        tick();

        // ---------------- randomized runs against the model ----------------
        for (int r = 0; r < 40; r++) begin
            lo = $urandom_range(0, 15);
            hi = $urandom_range(0, 15);
            if ((r % 5) != 0 && lo > hi) begin
                int t;
                t = lo; lo = hi; hi = t;
            end
            up = $urandom_range(0, 1);
            b  = $urandom_range(0, 1);
            p  = $urandom_range(0, 15);
            if (r % 4 == 0) p = $urandom_range(1, 3);
            if (lo > hi) begin
                start_run(lo, hi, up, b, p);
                check("rnd_err", 32'(bus.err), 1);
                check("rnd_err_busy", 32'(bus.busy), 0);
                tick();
                check("rnd_err_once", 32'(bus.err), 0);
            end else begin
                build_model(lo, hi, up, b, p);
                start_run(lo, hi, up, b, p);
                idx = 0;
                cyc = 0;
                expect_run("rnd_first", q[0]);
                forever begin
                    h = ($urandom_range(0, 3) == 0);
                    bus.hold  = h;
                    bus.start = 1'($urandom);
                    bus.lo    = W'($urandom);
                    bus.hi    = W'($urandom);
                    tick();
                    bus.start = 1'b0;
                    bus.hold  = 1'b0;
                    cyc++;
                    if (!h) idx++;
                    if (idx == q.size()) begin
                        check("rnd_done", 32'(bus.done), 1);
                        check("rnd_fbusy", 32'(bus.busy), 0);
                        check("rnd_fcount", 32'(bus.count), 32'(q[q.size()-1]));
                        check("rnd_fdir", 32'(bus.dir), 32'(model_fdir));
                        check("rnd_fpidx", 32'(bus.pass_idx), 32'(((p == 0) ? 16 : p) % 16));
                        break;
                    end
                    expect_run("rnd_step", q[idx]);
                    check("rnd_no_err", 32'(bus.err), 0);
                    if (cyc > 4 * q.size() + 40) begin
                        check("rnd_timeout", 32'd0, 32'd1);
                        break;
                    end
                end
                tick();
                check("rnd_done_once", 32'(bus.done), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, counter and bound width.
REQ-002 Port: clk  in  1  rising-edge clock; one clock domain only.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  in IDLE, latches config and begins a run; ignored otherwise.
REQ-005 Port: up_first  in  1  first sweep direction: 1=up (lo->hi), 0=down (hi->lo).
REQ-006 Port: bounce  in  1  1=reverse direction at each bound; 0=reload the start bound at each pass end.
REQ-007 Port: lo  in  WIDTH  lower bound, unsigned.
REQ-008 Port: hi  in  WIDTH  upper bound, unsigned.
REQ-009 Port: passes  in  4  pass count; 0 means 16 passes.
REQ-010 Port: hold  in  1  freezes count, direction and pass index while 1.
REQ-011 Port: abort  in  1  terminates any run; returns to IDLE.
REQ-012 Port: count  out  WIDTH  current counter value (registered).
REQ-013 Port: dir  out  1  current direction, 1=up.
REQ-014 Port: pass_idx  out  4  number of completed passes in the current run.
REQ-015 Port: busy  out  1  high in RUN.
REQ-016 Port: done  out  1  one-cycle pulse on normal completion.
REQ-017 Port: err  out  1  one-cycle pulse on rejected start (lo > hi).

Function
REQ-018 States SHALL be IDLE, RUN and DONE.
REQ-019 Config: lo, hi, up_first, bounce and passes SHALL be latched on the accepting start edge; later input changes SHALL NOT affect the run.
REQ-020 IDLE, start=1, lo<=hi: next state RUN; count<=lo if up_first else hi; dir<=up_first; pass_idx<=0. First count value is visible one cycle after start.
REQ-021 IDLE, start=1, lo>hi: err=1 for the next cycle only; state, count and the other outputs unchanged.
REQ-022 RUN, hold=0, count != end bound of the current direction: count SHALL step by exactly 1 toward that bound. The end bound is hi when up and lo when down.
REQ-023 RUN, hold=0, count == end bound: pass_idx SHALL increment; if the new value equals passes (16 when passes=0), next state is DONE and count holds.
REQ-024 Pass end, run continuing, bounce=1: dir SHALL flip and count SHALL step one toward the new end bound in the same edge, so a bound value is not repeated.
REQ-025 Pass end, run continuing, bounce=0: count SHALL reload the start bound; dir is unchanged.
REQ-026 lo==hi: every RUN cycle SHALL be a pass end and count SHALL stay at lo.
REQ-027 Count arithmetic SHALL never wrap modulo 2^WIDTH; bounds 0 and 2^WIDTH-1 SHALL be handled without overflow.
REQ-028 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; count, dir and pass_idx SHALL retain their final values.
REQ-029 hold=1 in RUN: all state SHALL be frozen; hold SHALL have no effect in IDLE or DONE.
REQ-030 abort=1 in any state: next state IDLE; count SHALL hold its value; done SHALL NOT pulse; busy=0 the next cycle.
REQ-031 Priority SHALL be abort > hold > normal stepping.
REQ-032 start while in RUN or DONE SHALL be ignored, with no err pulse.

Reset
REQ-033 While reset=1, asynchronously: state=IDLE, count=0, dir=1, pass_idx=0, busy=0, done=0, err=0.
REQ-034 Reset asserted during RUN SHALL abandon the run without a done pulse; operation SHALL resume on the first clk edge after deassertion.

Structure
REQ-035 The shared package SHALL hold the state encoding (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-036 The datapath SHALL be one sub-module, bounded_updown_counter, with ports load, load_val, en, up and count. The FSM and pass logic SHALL remain in count_seq_ctrl.

Verification
REQ-037 lo=3, hi=6, up_first=1, bounce=0, passes=2 -> count 3,4,5,6,3,4,5,6, then done pulse; count stays 6; pass_idx=2.
REQ-038 lo=3, hi=5, up_first=1, bounce=1, passes=2 -> count 3,4,5,4,3, then done; dir=0; count=3.
REQ-039 lo=0, hi=15, up_first=0, bounce=0, passes=1 -> count 15 down to 0, then done; no wrap to 15.
REQ-040 lo=9, hi=2, start -> err pulse for 1 cycle; busy stays 0; count unchanged.
REQ-041 During the run of REQ-037: hold for 3 cycles at count=5 -> count stays 5 and the sequence then resumes; abort at count=4 -> IDLE, count=4, no done pulse.
REQ-042 Reset asserted mid-run between clock edges -> count=0 and busy=0 immediately; passes=0 with lo=hi=7 -> done after 16 RUN cycles.
